// File: rtl/mmcm_sup_pkg.sv
// Shared types for the MMCM lock supervisor: FSM state encoding, retry counter width
// and a saturating increment helper.
package mmcm_sup_pkg;

  localparam int RETRY_W = 8;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } sup_state_t;

  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : v + RETRY_W'(1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Asynchronously cleared to 0; q follows d after STAGES clock edges.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/mmcm_lock_supervisor.sv
// Sequences MMCM reset/lock and holds sys_rst until lock has been stable.
// Define MMCM_SUP_FAULT_EN to give up (sticky fault) after MAX_RETRIES consecutive timeouts.
module mmcm_lock_supervisor
  import mmcm_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int SYNC_STAGES         = 2
`ifdef MMCM_SUP_FAULT_EN
  , parameter int MAX_RETRIES       = 8
`endif
) (
  input  logic               clk100,
  input  logic               rst,
  input  logic               locked_in,
  output logic               mmcm_rst,
  output logic               sys_rst,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count,
  output logic               fault,
  output logic [2:0]         state_o
);

  localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES
                                                                    : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int TIMER_W = $clog2(MAX_CYC) + 1;

  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  // The cycle in which WAIT_LOCK sees lock is the first stable cycle, so STABLE counts one fewer.
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 2);

  sup_state_t         state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [RETRY_W-1:0] retry_next;
  logic               locked_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk100),
    .rst (rst),
    .d   (locked_in),
    .q   (locked_s)
  );

  always_comb begin
    state_next = state;
    retry_next = retry_count;
    timer_next = timer + TIMER_W'(1);
    case (state)
      S_RESET: begin
        if (timer == RST_LAST) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_next = S_STABLE;
        end else if (timer == TIMEOUT_LAST) begin
          retry_next = sat_inc(retry_count);
`ifdef MMCM_SUP_FAULT_EN
          state_next = (retry_next >= RETRY_W'(MAX_RETRIES)) ? S_FAULT : S_RESET;
`else
          state_next = S_RESET;
`endif
        end
      end
      S_STABLE: begin
        if (!locked_s)                 state_next = S_WAIT_LOCK;
        else if (timer == STABLE_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        timer_next = timer;
        if (!locked_s) state_next = S_RESET;
      end
`ifdef MMCM_SUP_FAULT_EN
      S_FAULT: begin
        timer_next = timer;
      end
`endif
      default: state_next = S_RESET;
    endcase
    if (state_next != state) timer_next = '0;
    if (state_next == S_RUN && state != S_RUN) retry_next = '0;
  end

  // Outputs are decoded from state_next so they switch on the same edge as the state.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state       <= S_RESET;
      timer       <= '0;
      retry_count <= '0;
      mmcm_rst    <= 1'b1;
      sys_rst     <= 1'b1;
      lock_lost   <= 1'b0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      retry_count <= retry_next;
      mmcm_rst    <= (state_next == S_RESET) || (state_next == S_FAULT);
      sys_rst     <= (state_next != S_RUN);
      lock_lost   <= (state == S_RUN) && !locked_s;
    end
  end

`ifdef MMCM_SUP_FAULT_EN
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) fault <= 1'b0;
    else     fault <= fault | (state_next == S_FAULT);
  end
`else
  assign fault = 1'b0;
`endif

  assign state_o = state;

endmodule
